// File: rtl/dispatch_rename_ctrl.sv
// Dispatch and register-rename control: free-tag FIFO, rename table with
// CDB wakeup, issue-queue steering and stall accounting.
module dispatch_rename_ctrl #(
  parameter int TAG_W = 5,
  parameter int NUM_Q = 3,
  parameter int REG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Dec_valid,
  output logic               Dec_ready,
  input  logic [NUM_Q-1:0]   Dec_qsel,
  input  logic [REG_W-1:0]   Dec_rs_addr,
  input  logic [REG_W-1:0]   Dec_rt_addr,
  input  logic [REG_W-1:0]   Dec_rd_addr,
  input  logic               Dec_rd_write,
  input  logic [NUM_Q-1:0]   Iq_ready,
  output logic [NUM_Q-1:0]   Iq_valid,
  output logic [TAG_W-1:0]   Disp_rs_tag,
  output logic [TAG_W-1:0]   Disp_rt_tag,
  output logic [TAG_W-1:0]   Disp_rd_tag,
  output logic               Disp_rs_pend,
  output logic               Disp_rt_pend,
  input  logic               Rob_full,
  input  logic               Cdb_valid,
  input  logic [TAG_W-1:0]   Cdb_tag,
  input  logic               Retire_valid,
  input  logic [TAG_W-1:0]   Retire_tag,
  input  logic               Flush,
  output logic [TAG_W:0]     Free_count,
  output logic [15:0]        Stall_count,
  output logic               Err_overflow
);

  localparam int unsigned DEPTH = 1 << TAG_W;
  localparam int unsigned NREG  = 1 << REG_W;
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

  state_t state, state_nx;

  logic [TAG_W-1:0] fifo_mem [DEPTH];
  logic [TAG_W-1:0] rd_ptr, wr_ptr, init_cnt;
  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] map_tag [NREG];
  logic [NREG-1:0]  map_pend;
  logic [15:0]      stall_cnt;
  logic             err_q;

  logic active, wr_eff, fire, pop, push, ovf, full, init_last, retire_req;
  logic [TAG_W-1:0] head;

  // The Flush cycle is treated like INIT: decode, CDB and retire are ignored.
  assign active     = (state != INIT) & ~Flush;
  assign wr_eff     = Dec_rd_write & (Dec_rd_addr != '0);
  assign head       = fifo_mem[rd_ptr];
  assign full       = (count == FULL_CNT);
  assign init_last  = (init_cnt == '1);
  assign fire       = Dec_valid & Dec_ready;
  assign pop        = fire & wr_eff;
  assign retire_req = active & Retire_valid;
  assign push       = retire_req & (~full | pop);
  assign ovf        = retire_req & full & ~pop;

  always_comb begin
    state_nx  = state;
    Dec_ready = 1'b0;
    Iq_valid  = '0;
    Dec_ready = active & ~Rob_full & (|(Dec_qsel & Iq_ready)) &
                (~wr_eff | (count != '0));
    if (Dec_valid & Dec_ready) Iq_valid = Dec_qsel;
    if (Flush) begin
      state_nx = INIT;
    end else begin
      case (state)
        INIT:    if (init_last) state_nx = RUN;
        RUN:     if (Dec_valid & ~Dec_ready) state_nx = STALL;
        STALL:   if ((Dec_valid & Dec_ready) | ~Dec_valid) state_nx = RUN;
        default: state_nx = INIT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == STALL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ovf) err_q <= 1'b1;
      if (Flush) begin
        init_cnt <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_last) count <= FULL_CNT;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= count + {{TAG_W{1'b0}}, push} - {{TAG_W{1'b0}}, pop};
      end
    end
  end

  // Pool storage carries no reset; INIT rewrites every slot before use.
  always_ff @(posedge clock) begin
    if (state == INIT && !Flush) fifo_mem[init_cnt] <= init_cnt;
    else if (push)               fifo_mem[wr_ptr]   <= Retire_tag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) map_tag[i] <= '0;
      map_pend <= '0;
    end else if (Flush) begin
      map_pend <= '0;
    end else begin
      if (active && Cdb_valid) begin
        for (int unsigned i = 0; i < NREG; i++)
          if (map_tag[i] == Cdb_tag) map_pend[i] <= 1'b0;
      end
      // Placed after the wakeup loop so a same-cycle rename of rd wins.
      if (pop) begin
        map_tag[Dec_rd_addr]  <= head;
        map_pend[Dec_rd_addr] <= 1'b1;
      end
    end
  end

  assign Disp_rs_tag  = map_tag[Dec_rs_addr];
  assign Disp_rt_tag  = map_tag[Dec_rt_addr];
  assign Disp_rd_tag  = head;
  assign Disp_rs_pend = map_pend[Dec_rs_addr] & (Dec_rs_addr != '0) &
                        ~(Cdb_valid & (Cdb_tag == Disp_rs_tag));
  assign Disp_rt_pend = map_pend[Dec_rt_addr] & (Dec_rt_addr != '0) &
                        ~(Cdb_valid & (Cdb_tag == Disp_rt_tag));
  assign Free_count   = count;
  assign Stall_count  = stall_cnt;
  assign Err_overflow = err_q;

endmodule

// File: tb/tb_dispatch_rename_ctrl.sv
// Directed self-checking bench for dispatch_rename_ctrl with a 4-entry tag pool.
module tb_dispatch_rename_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Dec_valid = 1'b0, Dec_ready, Dec_rd_write = 1'b0;
  logic [2:0]  Dec_qsel = 3'b001, Iq_ready = 3'b111, Iq_valid;
  logic [4:0]  Dec_rs_addr = '0, Dec_rt_addr = '0, Dec_rd_addr = '0;
  logic [1:0]  Disp_rs_tag, Disp_rt_tag, Disp_rd_tag;
  logic        Disp_rs_pend, Disp_rt_pend;
  logic        Rob_full = 1'b0, Cdb_valid = 1'b0, Retire_valid = 1'b0, Flush = 1'b0;
  logic [1:0]  Cdb_tag = '0, Retire_tag = '0;
  logic [2:0]  Free_count;
  logic [15:0] Stall_count;
  logic        Err_overflow;

  int total = 0;
  int bad = 0;

  dispatch_rename_ctrl #(.TAG_W(2), .NUM_Q(3), .REG_W(5)) dut (
    .clock(clock), .reset(reset),
    .Dec_valid(Dec_valid), .Dec_ready(Dec_ready), .Dec_qsel(Dec_qsel),
    .Dec_rs_addr(Dec_rs_addr), .Dec_rt_addr(Dec_rt_addr), .Dec_rd_addr(Dec_rd_addr),
    .Dec_rd_write(Dec_rd_write), .Iq_ready(Iq_ready), .Iq_valid(Iq_valid),
    .Disp_rs_tag(Disp_rs_tag), .Disp_rt_tag(Disp_rt_tag), .Disp_rd_tag(Disp_rd_tag),
    .Disp_rs_pend(Disp_rs_pend), .Disp_rt_pend(Disp_rt_pend),
    .Rob_full(Rob_full), .Cdb_valid(Cdb_valid), .Cdb_tag(Cdb_tag),
    .Retire_valid(Retire_valid), .Retire_tag(Retire_tag), .Flush(Flush),
    .Free_count(Free_count), .Stall_count(Stall_count), .Err_overflow(Err_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic reinit;
    Dec_valid = 1'b0; Cdb_valid = 1'b0; Retire_valid = 1'b0; Flush = 1'b1;
    tick;
    Flush = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    Dec_valid = 1'b1; Dec_qsel = 3'b001; Iq_ready = 3'b111;
    #3;
    total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", Dec_ready); end
    total++; if (Iq_valid !== 3'b000) begin bad++; $display("FAIL reset_iqv got %b want 000", Iq_valid); end
    total++; if (Free_count !== 3'd0) begin bad++; $display("FAIL reset_free got %0d want 0", Free_count); end
    total++; if (Stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall got %0d want 0", Stall_count); end
    total++; if (Err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", Err_overflow); end
  endtask

  task automatic test_init;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL init_ready[%0d] got %b want 0", i, Dec_ready); end
      tick;
    end
    #1;
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL init_free got %0d want 4", Free_count); end
    total++; if (Dec_ready !== 1'b1) begin bad++; $display("FAIL init_fire_ready got %b want 1", Dec_ready); end
    total++; if (Iq_valid !== 3'b001) begin bad++; $display("FAIL init_fire_iqv got %b want 001", Iq_valid); end
    tick;
    Dec_valid = 1'b0;
  endtask

  task automatic test_rename;
    Dec_valid = 1'b1; Dec_rd_write = 1'b1; Dec_rd_addr = 5'd3; Dec_rs_addr = 5'd0; Dec_rt_addr = 5'd0;
    #1;
    total++; if (Disp_rd_tag !== 2'd0) begin bad++; $display("FAIL ren_rd0 got %0d want 0", Disp_rd_tag); end
    tick;
    Dec_rd_write = 1'b0; Dec_rs_addr = 5'd3; Dec_rt_addr = 5'd3;
    #1;
    total++; if (Disp_rs_tag !== 2'd0) begin bad++; $display("FAIL ren_rs_tag got %0d want 0", Disp_rs_tag); end
    total++; if (Disp_rs_pend !== 1'b1) begin bad++; $display("FAIL ren_rs_pend got %b want 1", Disp_rs_pend); end
    Cdb_valid = 1'b1; Cdb_tag = 2'd0;
    #1;
    total++; if (Disp_rs_pend !== 1'b0) begin bad++; $display("FAIL ren_bypass_rs got %b want 0", Disp_rs_pend); end
    total++; if (Disp_rt_pend !== 1'b0) begin bad++; $display("FAIL ren_bypass_rt got %b want 0", Disp_rt_pend); end
    tick;
    // rs == rd: source sees the old mapping, rd takes the next free tag
    Cdb_valid = 1'b0; Dec_rd_write = 1'b1; Dec_rd_addr = 5'd3; Dec_rt_addr = 5'd0;
    #1;
    total++; if (Disp_rs_pend !== 1'b0) begin bad++; $display("FAIL ren_cdb_clear got %b want 0", Disp_rs_pend); end
    total++; if (Disp_rs_tag !== 2'd0) begin bad++; $display("FAIL ren_old_map got %0d want 0", Disp_rs_tag); end
    total++; if (Disp_rd_tag !== 2'd1) begin bad++; $display("FAIL ren_rd1 got %0d want 1", Disp_rd_tag); end
    tick;
    // CDB clears old tag 1 while rd=3 is renamed again: new pend must survive
    Cdb_valid = 1'b1; Cdb_tag = 2'd1;
    #1;
    total++; if (Disp_rs_tag !== 2'd1) begin bad++; $display("FAIL ren_rs_tag1 got %0d want 1", Disp_rs_tag); end
    tick;
    Cdb_valid = 1'b0; Dec_valid = 1'b0; Dec_rd_write = 1'b0;
    #1;
    total++; if (Disp_rs_tag !== 2'd2) begin bad++; $display("FAIL ren_win_tag got %0d want 2", Disp_rs_tag); end
    total++; if (Disp_rs_pend !== 1'b1) begin bad++; $display("FAIL ren_win_pend got %b want 1", Disp_rs_pend); end
    total++; if (Free_count !== 3'd1) begin bad++; $display("FAIL ren_free got %0d want 1", Free_count); end
  endtask

  task automatic test_flush;
    Flush = 1'b1; Dec_valid = 1'b1; Dec_rd_write = 1'b1; Dec_rd_addr = 5'd4; Dec_rt_addr = 5'd4;
    #1;
    total++; if (Iq_valid !== 3'b000) begin bad++; $display("FAIL flush_iqv got %b want 000", Iq_valid); end
    tick;
    Flush = 1'b0; Dec_valid = 1'b0; Dec_rd_write = 1'b0;
    #1;
    total++; if (Free_count !== 3'd0) begin bad++; $display("FAIL flush_free got %0d want 0", Free_count); end
    total++; if (Disp_rs_pend !== 1'b0) begin bad++; $display("FAIL flush_rs_pend got %b want 0", Disp_rs_pend); end
    total++; if (Disp_rt_pend !== 1'b0) begin bad++; $display("FAIL flush_rt_pend got %b want 0", Disp_rt_pend); end
    Retire_valid = 1'b1; Retire_tag = 2'd3;
    for (int i = 0; i < 4; i++) begin
      total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL flush_init_ready[%0d] got %b want 0", i, Dec_ready); end
      tick;
    end
    Retire_valid = 1'b0;
    #1;
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL flush_refill got %0d want 4", Free_count); end
    total++; if (Err_overflow !== 1'b0) begin bad++; $display("FAIL flush_err got %b want 0", Err_overflow); end
  endtask

  task automatic test_stall;
    Dec_valid = 1'b1; Dec_rd_write = 1'b1; Dec_qsel = 3'b001; Dec_rs_addr = '0; Dec_rt_addr = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_tag;
      exp_tag = 2'(k);
      Dec_rd_addr = 5'(k + 1);
      #1;
      total++; if (Disp_rd_tag !== exp_tag) begin bad++; $display("FAIL stall_tag[%0d] got %0d want %0d", k, Disp_rd_tag, exp_tag); end
      total++; if (Iq_valid !== 3'b001) begin bad++; $display("FAIL stall_iqv[%0d] got %b want 001", k, Iq_valid); end
      tick;
    end
    Dec_rd_addr = 5'd5;
    #1;
    total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL stall_held got %b want 0", Dec_ready); end
    total++; if (Free_count !== 3'd0) begin bad++; $display("FAIL stall_empty got %0d want 0", Free_count); end
    tick; tick; tick;
    total++; if (Stall_count !== 16'd2) begin bad++; $display("FAIL stall_cnt2 got %0d want 2", Stall_count); end
    Retire_valid = 1'b1; Retire_tag = 2'd2;
    tick;
    Retire_valid = 1'b0;
    #1;
    total++; if (Dec_ready !== 1'b1) begin bad++; $display("FAIL stall_release got %b want 1", Dec_ready); end
    total++; if (Disp_rd_tag !== 2'd2) begin bad++; $display("FAIL stall_rd_tag got %0d want 2", Disp_rd_tag); end
    total++; if (Stall_count !== 16'd3) begin bad++; $display("FAIL stall_cnt3 got %0d want 3", Stall_count); end
    tick;
    Dec_valid = 1'b0; Dec_rd_write = 1'b0;
    tick;
    total++; if (Stall_count !== 16'd4) begin bad++; $display("FAIL stall_cnt_hold got %0d want 4", Stall_count); end
    total++; if (Free_count !== 3'd0) begin bad++; $display("FAIL stall_free_after got %0d want 0", Free_count); end
  endtask

  task automatic test_overflow;
    reinit;
    Dec_valid = 1'b1; Dec_rd_write = 1'b1; Dec_rd_addr = 5'd7; Retire_valid = 1'b1; Retire_tag = 2'd0;
    tick;
    Dec_valid = 1'b0; Dec_rd_write = 1'b0; Retire_valid = 1'b0;
    #1;
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL ovf_pushpop_free got %0d want 4", Free_count); end
    total++; if (Err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pushpop_err got %b want 0", Err_overflow); end
    Retire_valid = 1'b1; Retire_tag = 2'd1;
    tick;
    Retire_valid = 1'b0;
    #1;
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL ovf_free got %0d want 4", Free_count); end
    total++; if (Err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", Err_overflow); end
    tick; tick;
    total++; if (Err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", Err_overflow); end
  endtask

  task automatic test_qsel;
    Dec_valid = 1'b1; Dec_rd_write = 1'b0; Dec_qsel = 3'b010; Iq_ready = 3'b101;
    #1;
    total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL qsel_ready got %b want 0", Dec_ready); end
    total++; if (Iq_valid !== 3'b000) begin bad++; $display("FAIL qsel_iqv got %b want 000", Iq_valid); end
    Dec_qsel = 3'b001; Iq_ready = 3'b111; Rob_full = 1'b1;
    #1;
    total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL rob_full_ready got %b want 0", Dec_ready); end
    Rob_full = 1'b0; Dec_qsel = 3'b100; Dec_rd_write = 1'b1; Dec_rd_addr = 5'd0;
    #1;
    total++; if (Iq_valid !== 3'b100) begin bad++; $display("FAIL qsel_q2 got %b want 100", Iq_valid); end
    tick;
    Dec_valid = 1'b0; Dec_rd_write = 1'b0;
    #1;
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL r0_no_pop got %0d want 4", Free_count); end
  endtask

  task automatic test_reset_mid;
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    tick; tick;
    Dec_valid = 1'b1; Dec_qsel = 3'b001; Iq_ready = 3'b111;
    reset = 1'b1;
    #1;
    total++; if (Free_count !== 3'd0) begin bad++; $display("FAIL rmid_free got %0d want 0", Free_count); end
    total++; if (Stall_count !== 16'd0) begin bad++; $display("FAIL rmid_stall got %0d want 0", Stall_count); end
    total++; if (Err_overflow !== 1'b0) begin bad++; $display("FAIL rmid_err got %b want 0", Err_overflow); end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (Dec_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready[%0d] got %b want 0", i, Dec_ready); end
      tick;
    end
    #1;
    total++; if (Dec_ready !== 1'b1) begin bad++; $display("FAIL rmid_done got %b want 1", Dec_ready); end
    total++; if (Free_count !== 3'd4) begin bad++; $display("FAIL rmid_free4 got %0d want 4", Free_count); end
    total++; if (Disp_rd_tag !== 2'd0) begin bad++; $display("FAIL rmid_head got %0d want 0", Disp_rd_tag); end
    Dec_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_init;
    test_rename;
    test_flush;
    test_stall;
    test_overflow;
    test_qsel;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
